// File: rtl/hex_digit_counter_pkg.sv
// Shared widths and helpers for the multi-digit display counter.
// seg_decode returns active-high gfedcba glyphs for 0-F.
package hex_digit_counter_pkg;

  localparam int DIGIT_W = 4;
  localparam int SEG_W   = 7;

  function automatic logic [SEG_W-1:0] seg_decode(input logic [DIGIT_W-1:0] nibble);
    logic [SEG_W-1:0] glyph;
    case (nibble)
      4'h0:    glyph = 7'h3F;
      4'h1:    glyph = 7'h06;
      4'h2:    glyph = 7'h5B;
      4'h3:    glyph = 7'h4F;
      4'h4:    glyph = 7'h66;
      4'h5:    glyph = 7'h6D;
      4'h6:    glyph = 7'h7D;
      4'h7:    glyph = 7'h07;
      4'h8:    glyph = 7'h7F;
      4'h9:    glyph = 7'h6F;
      4'hA:    glyph = 7'h77;
      4'hB:    glyph = 7'h7C;
      4'hC:    glyph = 7'h39;
      4'hD:    glyph = 7'h5E;
      4'hE:    glyph = 7'h79;
      4'hF:    glyph = 7'h71;
      default: glyph = 7'h00;
    endcase
    return glyph;
  endfunction

  function automatic logic [DIGIT_W-1:0] digit_max(input logic bcd);
    return bcd ? 4'd9 : 4'd15;
  endfunction

endpackage

// File: rtl/hex_digit_counter_digit_cell.sv
// One counter digit: load/clear, up/down step gated by the carry chain,
// with hex or BCD wrap. carry_out doubles as borrow-out when counting down.
module digit_cell
  import hex_digit_counter_pkg::*;
#(
  parameter bit BCD = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_digit,
  input  logic               step,
  input  logic               up,
  input  logic               carry_in,
  output logic [DIGIT_W-1:0] value,
  output logic               carry_out
);

  localparam logic [DIGIT_W-1:0] MAX = digit_max(BCD);

  // A loaded BCD digit above 9 counts as "at max" going up but is not a borrow going down.
  logic at_limit;
  assign at_limit  = up ? (value >= MAX) : (value == '0);
  assign carry_out = carry_in && at_limit;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      value <= '0;
    end else if (load) begin
      value <= load_digit;
    end else if (step && carry_in) begin
      if (up) begin
        value <= at_limit ? '0 : value + 1'b1;
      end else begin
        value <= at_limit ? MAX : value - 1'b1;
      end
    end
  end

endmodule

// File: rtl/hex_digit_counter.sv
// N-digit hex/BCD display counter: prescaler tick, rippled digit chain,
// registered seven-segment outputs with optional leading-zero blanking.
module hex_digit_counter
  import hex_digit_counter_pkg::*;
#(
  parameter int DIGITS         = 8,
  parameter int CLK_FREQ_HZ    = 50000000,
  parameter int TICK_HZ        = 2,
  parameter bit BCD            = 1'b0,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      up,
  input  logic                      load,
  input  logic [DIGIT_W*DIGITS-1:0] load_value,
  input  logic                      clear,
  input  logic                      blank_lz,
  output logic [DIGIT_W*DIGITS-1:0] count,
  output logic                      tick_out,
  output logic                      carry,
  output logic [SEG_W*DIGITS-1:0]   segments
);

  localparam int DIV = CLK_FREQ_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'((DIV > 0) ? DIV - 1 : 0);
  localparam logic [SEG_W-1:0] SEG_OFF = {SEG_W{SEG_ACTIVE_LOW}};

  if (DIV < 1) begin : g_bad_div
    $error("hex_digit_counter: CLK_FREQ_HZ/TICK_HZ must be at least 1");
  end
  if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
    $error("hex_digit_counter: DIGITS must be in 1..8");
  end

  logic [PW-1:0] prescaler;
  logic          step;
  logic [DIGITS:0] chain;

  assign step     = enable && (prescaler == LAST);
  assign chain[0] = 1'b1;

  always_ff @(posedge clk) begin
    if (rst || clear || load) begin
      prescaler <= '0;
    end else if (enable) begin
      prescaler <= step ? '0 : prescaler + 1'b1;
    end
  end

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    digit_cell #(.BCD(BCD)) u_digit (
      .clk        (clk),
      .rst        (rst),
      .clear      (clear),
      .load       (load),
      .load_digit (load_value[i*DIGIT_W +: DIGIT_W]),
      .step       (step),
      .up         (up),
      .carry_in   (chain[i]),
      .value      (count[i*DIGIT_W +: DIGIT_W]),
      .carry_out  (chain[i+1])
    );
  end

  // The top of the carry chain fires only when every digit wrapped together.
  always_ff @(posedge clk) begin
    if (rst || clear || load) begin
      tick_out <= 1'b0;
      carry    <= 1'b0;
    end else begin
      tick_out <= step;
      carry    <= step && chain[DIGITS];
    end
  end

  logic [SEG_W*DIGITS-1:0] seg_next;
  logic                    upper_zero;
  logic [SEG_W-1:0]        glyph;

  // Walk from the top digit down, tracking whether everything so far is zero.
  always_comb begin
    seg_next   = '0;
    upper_zero = 1'b1;
    glyph      = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      upper_zero = upper_zero && (count[i*DIGIT_W +: DIGIT_W] == '0);
      glyph      = seg_decode(count[i*DIGIT_W +: DIGIT_W]);
      if (blank_lz && upper_zero && (i != 0)) begin
        glyph = '0;
      end
      seg_next[i*SEG_W +: SEG_W] = SEG_ACTIVE_LOW ? ~glyph : glyph;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      segments <= {DIGITS{SEG_OFF}};
    end else begin
      segments <= seg_next;
    end
  end

endmodule
